// File: rtl/risc_spm_pkg.sv
// Types and constants shared by the RISC_SPM core, its RAM and the boot loader.
// RISC_SPM_LOADER_CHECKSUM_EN adds the checksum state and the running-sum helper.
package risc_spm_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_ADDR = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
`ifdef RISC_SPM_LOADER_CHECKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // States in which the loader is still willing to take stream bytes.
    function automatic logic is_active(input state_t s);
        logic a;
        a = (s == S_ADDR) || (s == S_LEN) || (s == S_DATA);
`ifdef RISC_SPM_LOADER_CHECKSUM_EN
        a = a || (s == S_CHK);
`endif
        return a;
    endfunction

`ifdef RISC_SPM_LOADER_CHECKSUM_EN
    function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] b);
        return acc + b;
    endfunction
`endif

endpackage

// File: rtl/loader_timeout_ctr.sv
// Idle-cycle counter for the boot loader; tc flags the idle cycle that reaches LIMIT.
// LIMIT of 0 disables the terminal count entirely.
module loader_timeout_ctr #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : {CW{1'b0}};

    logic [CW-1:0] cnt_r;

    // Idle counter: cleared by a transfer or outside the timed states, saturates at LAST.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    generate
        if (LIMIT == 0) begin : g_off
            assign tc = 1'b0;
        end else begin : g_on
            assign tc = en && !clr && (cnt_r == LAST);
        end
    endgenerate

endmodule

// File: rtl/risc_spm_loader.sv
// Boot loader: writes a framed byte stream (addr, len, data[, checksum]) into the
// RISC_SPM RAM and releases the core's reset once the frame is in. Option: RISC_SPM_LOADER_CHECKSUM_EN.
module risc_spm_loader #(
    parameter int ADDR_W  = risc_spm_pkg::ADDR_W,
    parameter int DATA_W  = risc_spm_pkg::DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   count_left
);
    import risc_spm_pkg::*;

    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_LEFT = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_r, state_n;
    logic              in_ready_r, mem_we_r, cpu_rst_r, done_r, error_r;
    logic [ADDR_W-1:0] ptr_r, mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [ADDR_W:0]   count_left_r;
    logic              xfer_s, tc_s, idle_en_s;
`ifdef RISC_SPM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_r;
`endif

    assign xfer_s    = in_valid && in_ready_r;
    assign idle_en_s = is_active(state_r) && (state_r != S_ADDR);

    loader_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (xfer_s || !idle_en_s),
        .en  (idle_en_s),
        .tc  (tc_s)
    );

    // Next-state logic of the frame parser.
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_ADDR: begin
                if (xfer_s) state_n = S_LEN;
                else        state_n = S_ADDR;
            end
            S_LEN: begin
                if (xfer_s)    state_n = S_DATA;
                else if (tc_s) state_n = S_ERR;
                else           state_n = S_LEN;
            end
            S_DATA: begin
                if (xfer_s && (count_left_r == ONE_LEFT)) begin
`ifdef RISC_SPM_LOADER_CHECKSUM_EN
                    state_n = S_CHK;
`else
                    state_n = S_DONE;
`endif
                end else if (tc_s) begin
                    state_n = S_ERR;
                end else begin
                    state_n = S_DATA;
                end
            end
`ifdef RISC_SPM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer_s) begin
                    if (csum_add(sum_r, in_data) == {DATA_W{1'b0}}) state_n = S_DONE;
                    else                                            state_n = S_ERR;
                end else if (tc_s) begin
                    state_n = S_ERR;
                end else begin
                    state_n = S_CHK;
                end
            end
`endif
            S_DONE:  state_n = S_DONE;
            S_ERR:   state_n = S_ERR;
            default: state_n = S_ERR;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_r <= S_ADDR;
        else      state_r <= state_n;
    end

    // Datapath: pointer, remaining count, RAM write port and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r        <= {ADDR_W{1'b0}};
            count_left_r <= {(ADDR_W+1){1'b0}};
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            in_ready_r   <= 1'b0;
            cpu_rst_r    <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
`ifdef RISC_SPM_LOADER_CHECKSUM_EN
            sum_r        <= {DATA_W{1'b0}};
`endif
        end else begin
            mem_we_r <= 1'b0;
            case (state_r)
                S_ADDR: begin
                    if (xfer_s) begin
                        ptr_r <= in_data[ADDR_W-1:0];
`ifdef RISC_SPM_LOADER_CHECKSUM_EN
                        sum_r <= in_data;
`endif
                    end
                end
                S_LEN: begin
                    if (xfer_s) begin
                        count_left_r <= (in_data == {DATA_W{1'b0}}) ? FULL_LEN
                                                                    : {1'b0, in_data[ADDR_W-1:0]};
`ifdef RISC_SPM_LOADER_CHECKSUM_EN
                        sum_r <= csum_add(sum_r, in_data);
`endif
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        mem_we_r     <= 1'b1;
                        mem_addr_r   <= ptr_r;
                        mem_wdata_r  <= in_data;
                        ptr_r        <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        count_left_r <= count_left_r - ONE_LEFT;
`ifdef RISC_SPM_LOADER_CHECKSUM_EN
                        sum_r <= csum_add(sum_r, in_data);
`endif
                    end
                end
                default: begin
                end
            endcase
            // Ready follows the next state so no byte is taken on entry to DONE/ERR.
            in_ready_r <= is_active(state_n);
            // Release lags DONE entry by one cycle so the last write precedes it.
            cpu_rst_r  <= (state_r == S_DONE);
            done_r     <= (state_r == S_DONE);
            error_r    <= (state_r == S_ERR);
        end
    end

    assign in_ready   = in_ready_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign cpu_rst    = cpu_rst_r;
    assign done       = done_r;
    assign error      = error_r;
    assign count_left = count_left_r;

endmodule

// File: tb/tb_risc_spm_loader.sv
// Self-checking bench for risc_spm_loader: frame loads, wrap, full depth, abort, timeout.
module tb_risc_spm_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, mem_we, cpu_rst, done, error;
    logic [7:0] mem_addr, mem_wdata;
    logic [8:0] count_left;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;
    logic [15:0] sb_q[$];
    logic [7:0]  payload[$];

    always #5 clk = ~clk;

    risc_spm_loader #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error),
        .count_left (count_left)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one byte, wait for acceptance, then check the write port one cycle later.
    task automatic send_byte(input logic [7:0] b, input logic is_data);
        int n;
        logic [15:0] exp;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        stall_cycles += n;
        checks++;
        if (n >= 64) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if (is_data) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
            if (mem_we !== 1'b1 || {mem_addr, mem_wdata} !== exp) begin
                errors++;
                $display("FAIL write: got we=%b addr=%0d data=%0d required we=1 addr=%0d data=%0d",
                         mem_we, mem_addr, mem_wdata, exp[15:8], exp[7:0]);
            end
        end else begin
            if (mem_we !== 1'b0) begin
                errors++;
                $display("FAIL no_write: got we=%b required 0", mem_we);
            end
        end
    endtask

    task automatic load_frame(input logic [7:0] a, input logic [8:0] n,
                              input logic use_chk, input logic [7:0] chk);
        logic [7:0] s;
        logic [7:0] cval;
        logic [8:0] expc;
        s = a + n[7:0];
        send_byte(a, 1'b0);
        send_byte(n[7:0], 1'b0);
        checks++;
        if (count_left !== n) begin
            errors++;
            $display("FAIL count_left_len: got %0d required %0d", count_left, n);
        end
        for (int i = 0; i < int'(n); i++) begin
            sb_q.push_back({a + 8'(i), payload[i]});
            s = s + payload[i];
            send_byte(payload[i], 1'b1);
            expc = n - 9'(i + 1);
            checks++;
            if (count_left !== expc) begin
                errors++;
                $display("FAIL count_left_step: got %0d required %0d", count_left, expc);
            end
        end
        cval = use_chk ? chk : (8'h00 - s);
`ifdef RISC_SPM_LOADER_CHECKSUM_EN
        send_byte(cval, 1'b0);
`endif
        in_valid = 1'b0;
    endtask

    task automatic wait_end;
        int n;
        n = 0;
        while (!done && !error && n < 32) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 32) begin
            errors++;
            $display("FAIL end_timeout: done=%b error=%b required one set", done, error);
        end
    endtask

    task automatic check_done(input string tag);
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b1 || error !== 1'b0 || in_ready !== 1'b0
            || sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: done=%b cpu_rst=%b error=%b in_ready=%b pending=%0d required 1 1 0 0 0",
                     tag, done, cpu_rst, error, in_ready, sb_q.size());
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, mem_we, cpu_rst, done, error, mem_addr, mem_wdata, count_left} !== 30'd0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b we=%b crst=%b done=%b err=%b addr=%0d wd=%0d cl=%0d required all 0",
                     in_ready, mem_we, cpu_rst, done, error, mem_addr, mem_wdata, count_left);
        end
        rst = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_early: got %b required 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_rise: got %b required 1", in_ready);
        end
    endtask

    task automatic test_demo;
        payload = '{8'h00, 8'h52, 8'd130, 8'h01, 8'h0A, 8'h8B, 8'h20, 8'h03,
                    8'h44, 8'hA5, 8'h07, 8'hF0, 8'h0F, 8'h33, 8'hC0};
        load_frame(8'd0, 9'd15, 1'b0, 8'h00);
`ifndef RISC_SPM_LOADER_CHECKSUM_EN
        checks++;
        if (done !== 1'b0 || cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL demo_early_release: done=%b cpu_rst=%b required 0 0", done, cpu_rst);
        end
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL demo_extra_write: got we=%b required 0", mem_we);
        end
`else
        wait_end();
`endif
        check_done("demo_done");
        in_valid = 1'b1;
        in_data  = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL done_ignores_input: we=%b done=%b required 0 1", mem_we, done);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_wrap;
        do_reset();
        payload = '{8'd11, 8'd22, 8'd33, 8'd44};
        load_frame(8'd254, 9'd4, 1'b0, 8'h00);
        wait_end();
        check_done("wrap_done");
    endtask

    task automatic test_full;
        do_reset();
        payload.delete();
        for (int i = 0; i < 256; i++) payload.push_back(8'($urandom_range(0, 255)));
        stall_cycles = 0;
        load_frame(8'h37, 9'd256, 1'b0, 8'h00);
        checks++;
        if (stall_cycles != 0) begin
            errors++;
            $display("FAIL full_bubbles: got %0d stall cycles required 0", stall_cycles);
        end
        wait_end();
        check_done("full_done");
    endtask

    task automatic test_abort;
        do_reset();
        payload = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        send_byte(8'd16, 1'b0);
        send_byte(8'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back({8'd16 + 8'(i), payload[i]});
            send_byte(payload[i], 1'b1);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, mem_we, cpu_rst, done, error, mem_addr, mem_wdata, count_left} !== 30'd0) begin
            errors++;
            $display("FAIL abort_reset: rdy=%b we=%b crst=%b done=%b err=%b addr=%0d wd=%0d cl=%0d required all 0",
                     in_ready, mem_we, cpu_rst, done, error, mem_addr, mem_wdata, count_left);
        end
        rst = 1'b1;
        @(negedge clk);
        payload = '{8'h5A, 8'hC3, 8'h0E};
        load_frame(8'd40, 9'd3, 1'b0, 8'h00);
        wait_end();
        check_done("abort_reload_done");
    endtask

    task automatic test_timeout;
        do_reset();
        send_byte(8'd60, 1'b0);
        send_byte(8'd4, 1'b0);
        sb_q.push_back({8'd60, 8'h10});
        send_byte(8'h10, 1'b1);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL short_gap: error=%b required 0", error);
        end
        sb_q.push_back({8'd61, 8'h20});
        send_byte(8'h20, 1'b1);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_early: error=%b in_ready=%b required 0 1", error, in_ready);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (error !== 1'b1 || in_ready !== 1'b0 || cpu_rst !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: error=%b in_ready=%b cpu_rst=%b done=%b required 1 0 0 0",
                     error, in_ready, cpu_rst, done);
        end
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0 || count_left !== 9'd2 || error !== 1'b1) begin
                errors++;
                $display("FAIL err_ignores_input: we=%b count_left=%0d error=%b required 0 2 1",
                         mem_we, count_left, error);
            end
        end
        in_valid = 1'b0;
    endtask

`ifdef RISC_SPM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        do_reset();
        payload = '{8'd6, 8'd1};
        load_frame(8'd128, 9'd2, 1'b1, 8'h77);
        wait_end();
        check_done("chk_good");
        do_reset();
        load_frame(8'd128, 9'd2, 1'b1, 8'h00);
        wait_end();
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL chk_bad: error=%b done=%b cpu_rst=%b required 1 0 0", error, done, cpu_rst);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_demo();
        test_wrap();
        test_full();
        test_abort();
        test_timeout();
`ifdef RISC_SPM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc_spm_loader.md
Name: risc_spm_loader

Overview:
Boot-time program loader directly upstream of the RISC_SPM core. It receives a framed byte stream on a valid/ready interface and writes the bytes into the core's 256x8 RAM through a dedicated write port. The core is held in reset (its active-low rst) until the frame has been written completely. This replaces bench-side hierarchical preloading of memory with a synthesizable load path.

Parameters:
ADDR_W, 8, RAM address width; RAM depth is 2**ADDR_W
DATA_W, 8, RAM word and stream byte width
TIMEOUT, 1024, maximum idle cycles between bytes inside a frame before the loader aborts; 0 disables the timeout

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  reset, synchronous, active-low
in_data  in  DATA_W  stream byte
in_valid  in  1  stream byte valid
in_ready  out  1  loader can accept a byte
mem_addr  out  ADDR_W  RAM write address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write strobe, one-cycle pulse
cpu_rst  out  1  active-low reset to RISC_SPM; 0 holds the core
done  out  1  frame loaded, core released
error  out  1  frame aborted, core stays held
count_left  out  ADDR_W+1  data bytes still expected in the current frame

Behaviour:
- Frame format: byte0 = start address A; byte1 = length N, where 0 encodes 256 (full depth); then N data bytes. With CHECKSUM_EN, one further checksum byte follows.
- A byte transfers when in_valid && in_ready are both high at a posedge.
- FSM states: S_ADDR, S_LEN, S_DATA, (S_CHK), S_DONE, S_ERR.
- Reset (rst=0 at a posedge) forces: S_ADDR, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=0, done=0, error=0, count_left=0, timeout counter cleared. Reset also aborts any frame in progress; RAM contents are left untouched.
- in_ready is registered. It is 1 in S_ADDR/S_LEN/S_DATA/S_CHK and 0 in S_DONE/S_ERR. It first rises one cycle after rst deasserts.
- S_ADDR: on transfer, latch A into the pointer, then go to S_LEN.
- S_LEN: on transfer, set count_left to N (or 256 when N=0), then go to S_DATA.
- S_DATA: on each transfer, in the next cycle mem_we=1, mem_addr=pointer, mem_wdata=byte (write latency 1). The pointer then increments modulo 2**ADDR_W, so address 255 wraps to 0. count_left decrements. On the transfer that brings count_left to 0, go to S_CHK if CHECKSUM_EN is defined, else S_DONE.
- S_DONE: cpu_rst=1 and done=1, registered. They assert in the cycle after the last mem_we pulse, so the final write always lands before the core leaves reset. The loader stays here until rst.
- Timeout: a counter clears on every transfer and counts idle cycles while in S_LEN/S_DATA/S_CHK. When it reaches TIMEOUT, go to S_ERR. S_ADDR never times out.
- S_ERR: error=1, cpu_rst=0, in_ready=0. The loader stays here until rst.
- in_valid in S_DONE/S_ERR is ignored; no transfer occurs.
- Back-to-back transfers every cycle are supported with no bubbles.

Optional Feature:
- Macro: RISC_SPM_LOADER_CHECKSUM_EN.
- Defined: a checksum byte follows the data. The 8-bit modulo-256 sum of A, N and all data bytes plus the checksum byte must equal 0x00. On match, go to S_DONE; on mismatch, go to S_ERR. Writes already made stay in RAM.
- Undefined: no S_CHK state and no accumulator; the frame ends after the last data byte.

Decomposition:
- Package risc_spm_pkg holds the FSM state encoding typedef and the width constants ADDR_W=8 and DATA_W=8, shared with the core and its RAM.
- One sub-module, loader_timeout_ctr: idle counter with clear, enable, and a terminal-count flag.
- The FSM and datapath stay in risc_spm_loader.

Test Plan:
- Frame A=0, N=15, bytes equal to the existing demo program in memory[0..14] (0x00, 0x52, 130, ...). Expect 15 mem_we pulses at addresses 0..14 with matching data, then cpu_rst=1 and done=1 one cycle after the last pulse. Afterwards the core runs the program and reaches HALT at address 139.
- Frame A=254, N=4, data 11, 22, 33, 44. Expect writes to addresses 254, 255, 0, 1 (wrap-around); count_left steps 4, 3, 2, 1, 0.
- Frame with N=0 and in_valid held high. Expect 256 consecutive writes with no bubbles, then done=1.
- Assert rst=0 after 3 of 5 data bytes. Expect all outputs at reset values next cycle and cpu_rst=0. A fresh frame then loads correctly.
- With TIMEOUT=8, stall in_valid for 8 cycles mid-data. Expect error=1, in_ready=0, cpu_rst=0, and later bytes ignored.
- With CHECKSUM_EN, A=128, N=2, data 6, 1. A checksum byte of 0x77 gives done=1; a checksum byte of 0x00 gives error=1.
